// File: rtl/y86_seq_controller.sv
// y86_seq_controller
// Multi-cycle stage sequencer for the sequential Y86-64 datapath. It walks
// FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK -> PCUPD and retires
// one instruction per pass. It owns the PC, the condition codes, the
// processor status and the retired-instruction counter. It also drives the
// memory request strobes and the register-file write strobe.
module y86_seq_controller #(
   parameter logic [63:0] RESET_PC    = 64'd64,
   parameter int          MEM_TIMEOUT = 16,
   parameter int          CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           icode,
   input  logic [3:0]           ifun,
   input  logic                 valid_instruction,
   input  logic                 valid_memory,
   input  logic [63:0]          valP,
   input  logic [63:0]          valC,
   input  logic [63:0]          valM,
   input  logic                 cnd,
   input  logic [2:0]           out_CC,
   input  logic                 mem_ready,
   input  logic                 mem_error,
   output logic [63:0]          PC,
   output logic [2:0]           in_CC,
   output logic [2:0]           stage,
   output logic                 mem_rd,
   output logic                 mem_wr,
   output logic                 reg_we,
   output logic [2:0]           stat,
   output logic                 halted,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_PCUPD     = 3'd5,
      S_HALT      = 3'd6
   } state_t;

   localparam logic [2:0] STAT_AOK = 3'd1;
   localparam logic [2:0] STAT_HLT = 3'd2;
   localparam logic [2:0] STAT_ADR = 3'd3;
   localparam logic [2:0] STAT_INS = 3'd4;

   localparam logic [3:0] I_HALT   = 4'h0;
   localparam logic [3:0] I_CMOVXX = 4'h2;
   localparam logic [3:0] I_IRMOVQ = 4'h3;
   localparam logic [3:0] I_RMMOVQ = 4'h4;
   localparam logic [3:0] I_MRMOVQ = 4'h5;
   localparam logic [3:0] I_OPQ    = 4'h6;
   localparam logic [3:0] I_JXX    = 4'h7;
   localparam logic [3:0] I_CALL   = 4'h8;
   localparam logic [3:0] I_RET    = 4'h9;
   localparam logic [3:0] I_PUSHQ  = 4'hA;
   localparam logic [3:0] I_POPQ   = 4'hB;

   // The timeout counter only has to reach MEM_TIMEOUT-1, its last waiting cycle.
   localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

   state_t                 r_state;
   logic [63:0]            r_pc;
   logic [2:0]             r_cc;
   logic [2:0]             r_stat;
   logic [CNT_WIDTH-1:0]   r_icount;
   logic [TW-1:0]          r_tmo;

   logic                   w_is_wr;
   logic                   w_is_rd;
   logic                   w_writes_reg;
   logic [63:0]            w_pc_next;
   logic                   w_unused;

   // ifun selects the ALU op or condition downstream; sequencing ignores it.
   assign w_unused = ^ifun;

   // Decode the instruction classes used for sequencing and strobes.
   always_comb begin
      w_is_wr      = (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
      w_is_rd      = (icode == I_MRMOVQ) || (icode == I_RET)  || (icode == I_POPQ);
      w_writes_reg = 1'b0;
      case (icode)
         I_CMOVXX:                             w_writes_reg = cnd;
         I_IRMOVQ, I_MRMOVQ, I_OPQ,
         I_CALL, I_RET, I_PUSHQ, I_POPQ:       w_writes_reg = 1'b1;
         default:                              w_writes_reg = 1'b0;
      endcase
   end

   // Select the PC of the next instruction. All arithmetic wraps at 64 bits.
   always_comb begin
      w_pc_next = valP;
      case (icode)
         I_JXX:   w_pc_next = cnd ? valC : valP;
         I_CALL:  w_pc_next = valC;
         I_RET:   w_pc_next = valM;
         default: w_pc_next = valP;
      endcase
   end

   // Stage FSM together with the architectural state it owns.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_FETCH;
         r_pc     <= RESET_PC;
         r_cc     <= 3'b100;
         r_stat   <= STAT_AOK;
         r_icount <= '0;
         r_tmo    <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               // Faults leave the PC pointing at the offending instruction.
               if (!valid_memory) begin
                  r_stat  <= STAT_ADR;
                  r_state <= S_HALT;
               end else if (!valid_instruction) begin
                  r_stat  <= STAT_INS;
                  r_state <= S_HALT;
               end else if (icode == I_HALT) begin
                  r_stat  <= STAT_HLT;
                  r_state <= S_HALT;
               end else begin
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_state <= S_EXECUTE;
            end
            S_EXECUTE: begin
               if (icode == I_OPQ) begin
                  r_cc <= out_CC;
               end
               if (w_is_wr || w_is_rd) begin
                  r_tmo   <= '0;
                  r_state <= S_MEMORY;
               end else begin
                  r_state <= S_WRITEBACK;
               end
            end
            S_MEMORY: begin
               // A ready that shows up on the last waiting cycle still wins.
               if (mem_ready) begin
                  if (mem_error) begin
                     r_stat  <= STAT_ADR;
                     r_state <= S_HALT;
                  end else begin
                     r_state <= S_WRITEBACK;
                  end
               end else if (r_tmo == TMO_LAST) begin
                  r_stat  <= STAT_ADR;
                  r_state <= S_HALT;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            S_WRITEBACK: begin
               r_state <= S_PCUPD;
            end
            S_PCUPD: begin
               r_pc     <= w_pc_next;
               r_icount <= r_icount + CNT_WIDTH'(1);
               r_state  <= S_FETCH;
            end
            S_HALT: begin
               r_state <= S_HALT;
            end
            default: begin
               r_state <= S_HALT;
            end
         endcase
      end
   end

   // Strobes follow the current state, so they drop as soon as the state leaves MEMORY or WRITEBACK.
   always_comb begin
      mem_wr = (r_state == S_MEMORY)    && w_is_wr;
      mem_rd = (r_state == S_MEMORY)    && w_is_rd;
      reg_we = (r_state == S_WRITEBACK) && w_writes_reg;
      halted = (r_state == S_HALT);
   end

   assign PC          = r_pc;
   assign in_CC       = r_cc;
   assign stage       = r_state;
   assign stat        = r_stat;
   assign instr_count = r_icount;

endmodule

// File: tb/tb_y86_seq_controller.sv
// Directed bench for y86_seq_controller. Expected values are queued when an
// instruction is set up. They are popped and compared once the controller
// has had time to produce its result.
module tb_y86_seq_controller;

   logic        clk;
   logic        reset;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic        valid_instruction;
   logic        valid_memory;
   logic [63:0] valP;
   logic [63:0] valC;
   logic [63:0] valM;
   logic        cnd;
   logic [2:0]  out_CC;
   logic        mem_ready;
   logic        mem_error;
   logic [63:0] PC;
   logic [2:0]  in_CC;
   logic [2:0]  stage;
   logic        mem_rd;
   logic        mem_wr;
   logic        reg_we;
   logic [2:0]  stat;
   logic        halted;
   logic [31:0] instr_count;

   typedef struct {
      string       tag;
      logic [63:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_cmp;
   int   n_fail;
   int   cnt_we;
   int   cnt_rd;
   int   cnt_wr;

   y86_seq_controller #(
      .RESET_PC   (64'd64),
      .MEM_TIMEOUT(16),
      .CNT_WIDTH  (32)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .icode            (icode),
      .ifun             (ifun),
      .valid_instruction(valid_instruction),
      .valid_memory     (valid_memory),
      .valP             (valP),
      .valC             (valC),
      .valM             (valM),
      .cnd              (cnd),
      .out_CC           (out_CC),
      .mem_ready        (mem_ready),
      .mem_error        (mem_error),
      .PC               (PC),
      .in_CC            (in_CC),
      .stage            (stage),
      .mem_rd           (mem_rd),
      .mem_wr           (mem_wr),
      .reg_we           (reg_we),
      .stat             (stat),
      .halted           (halted),
      .instr_count      (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guard against a run that never reaches its summary.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic push(input string tag, input logic [63:0] val);
      exp_t e;
      e.tag = tag;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic cmp(input logic [63:0] obs);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty observed=%0d expected=<entry>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
         end
      end
   endtask

   // Advance n clocks, sampling 1 time unit after each edge and counting strobes.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (reg_we) cnt_we++;
         if (mem_rd) cnt_rd++;
         if (mem_wr) cnt_wr++;
      end
   endtask

   task automatic clr_strobes();
      cnt_we = 0;
      cnt_rd = 0;
      cnt_wr = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      clr_strobes();
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      reset = 1'b1;
      icode = 4'h1;
      ifun = 4'h0;
      valid_instruction = 1'b1;
      valid_memory = 1'b1;
      valP = 64'd65;
      valC = 64'd0;
      valM = 64'd0;
      cnd = 1'b0;
      out_CC = 3'b000;
      mem_ready = 1'b0;
      mem_error = 1'b0;
      clr_strobes();

      // Reset state
      push("rst_pc", 64);
      push("rst_cc", 3'b100);
      push("rst_stat", 1);
      push("rst_stage", 0);
      push("rst_halted", 0);
      push("rst_count", 0);
      step(2);
      cmp(PC);
      cmp(64'(in_CC));
      cmp(64'(stat));
      cmp(64'(stage));
      cmp(64'(halted));
      cmp(64'(instr_count));
      reset = 1'b0;

      // nop at 64, then halt at 65
      push("nop_pc", 65);
      push("nop_count", 1);
      push("nop_stage", 0);
      push("nop_we", 0);
      step(5);
      cmp(PC);
      cmp(64'(instr_count));
      cmp(64'(stage));
      cmp(64'(cnt_we));
      icode = 4'h0;
      push("hlt_stat", 2);
      push("hlt_halted", 1);
      push("hlt_stage", 6);
      push("hlt_pc", 65);
      push("hlt_count", 1);
      step(1);
      cmp(64'(stat));
      cmp(64'(halted));
      cmp(64'(stage));
      cmp(PC);
      cmp(64'(instr_count));
      icode = 4'h1;
      push("hlt_hold_pc", 65);
      push("hlt_hold_stage", 6);
      push("hlt_hold_count", 1);
      step(4);
      cmp(PC);
      cmp(64'(stage));
      cmp(64'(instr_count));

      // irmovq: MEMORY skipped, one reg_we pulse
      do_reset();
      icode = 4'h3;
      valP = 64'd74;
      push("irm_s1", 1);
      push("irm_s2", 2);
      push("irm_s3_wb", 4);
      push("irm_we_wb", 1);
      push("irm_s4", 5);
      push("irm_pc", 74);
      push("irm_we_cnt", 1);
      push("irm_mem_cnt", 0);
      step(1); cmp(64'(stage));
      step(1); cmp(64'(stage));
      step(1); cmp(64'(stage)); cmp(64'(reg_we));
      step(1); cmp(64'(stage));
      step(1); cmp(PC);
      cmp(64'(cnt_we));
      cmp(64'(cnt_rd + cnt_wr));

      // OPq updates CC at the exit of EXECUTE
      clr_strobes();
      icode = 4'h6;
      out_CC = 3'b010;
      valP = 64'd76;
      push("opq_cc_in_exec", 3'b100);
      push("opq_cc_after", 3'b010);
      push("opq_pc", 76);
      push("opq_we_cnt", 1);
      step(2); cmp(64'(in_CC));
      step(1); cmp(64'(in_CC));
      step(2); cmp(PC);
      cmp(64'(cnt_we));

      // jXX taken; CC must not change
      clr_strobes();
      icode = 4'h7;
      out_CC = 3'b111;
      cnd = 1'b1;
      valC = 64'd200;
      valP = 64'd85;
      push("jtk_pc", 200);
      push("jtk_cc", 3'b010);
      push("jtk_we_cnt", 0);
      step(5);
      cmp(PC);
      cmp(64'(in_CC));
      cmp(64'(cnt_we));

      // jXX not taken
      cnd = 1'b0;
      valP = 64'd105;
      push("jnt_pc", 105);
      push("jnt_count", 4);
      step(5);
      cmp(PC);
      cmp(64'(instr_count));

      // mrmovq with mem_ready in the 4th MEMORY cycle
      clr_strobes();
      icode = 4'h5;
      valP = 64'd115;
      push("mrm_stage_mem", 3);
      push("mrm_rd_cnt", 4);
      push("mrm_stage_wb", 4);
      push("mrm_pc", 115);
      push("mrm_we_cnt", 1);
      push("mrm_wr_cnt", 0);
      step(3); cmp(64'(stage));
      step(3);
      mem_ready = 1'b1;
      cmp(64'(cnt_rd));
      step(1); cmp(64'(stage));
      mem_ready = 1'b0;
      step(2); cmp(PC);
      cmp(64'(cnt_we));
      cmp(64'(cnt_wr));

      // mrmovq with a faulting memory access
      clr_strobes();
      valP = 64'd125;
      push("mer_stat", 3);
      push("mer_halted", 1);
      push("mer_pc", 115);
      push("mer_we_cnt", 0);
      push("mer_count", 5);
      step(6);
      mem_ready = 1'b1;
      mem_error = 1'b1;
      step(1);
      mem_ready = 1'b0;
      mem_error = 1'b0;
      step(2);
      cmp(64'(stat));
      cmp(64'(halted));
      cmp(PC);
      cmp(64'(cnt_we));
      cmp(64'(instr_count));

      // Reset asserted mid-access in MEMORY
      do_reset();
      icode = 4'h5;
      valP = 64'd73;
      push("rmm_rd_before", 1);
      push("rmm_stage", 0);
      push("rmm_rd_after", 0);
      push("rmm_pc", 64);
      step(3); cmp(64'(mem_rd));
      reset = 1'b1;
      step(1);
      cmp(64'(stage));
      cmp(64'(mem_rd));
      cmp(PC);
      reset = 1'b0;

      // Illegal opcode
      clr_strobes();
      icode = 4'h1;
      valid_instruction = 1'b0;
      push("ins_stat", 4);
      push("ins_stage", 6);
      push("ins_pc", 64);
      step(1);
      cmp(64'(stat));
      cmp(64'(stage));
      cmp(PC);
      valid_instruction = 1'b1;

      // Bad fetch address, checked ahead of the opcode check
      do_reset();
      valid_memory = 1'b0;
      valid_instruction = 1'b0;
      push("adr_stat", 3);
      push("adr_halted", 1);
      step(1);
      cmp(64'(stat));
      cmp(64'(halted));
      valid_memory = 1'b1;
      valid_instruction = 1'b1;

      // rmmovq with mem_ready never asserted
      do_reset();
      icode = 4'h4;
      valP = 64'd74;
      push("tmo_stage_last", 3);
      push("tmo_wr_cnt", 16);
      push("tmo_stat", 3);
      push("tmo_stage_halt", 6);
      push("tmo_wr_after", 0);
      push("tmo_pc", 64);
      step(18);
      cmp(64'(stage));
      cmp(64'(cnt_wr));
      step(1);
      cmp(64'(stat));
      cmp(64'(stage));
      cmp(64'(mem_wr));
      cmp(PC);

      // ret takes the PC from valM
      do_reset();
      icode = 4'h9;
      valM = 64'd300;
      valP = 64'd65;
      mem_ready = 1'b1;
      push("ret_pc", 300);
      push("ret_rd_cnt", 1);
      push("ret_count", 1);
      step(6);
      cmp(PC);
      cmp(64'(cnt_rd));
      cmp(64'(instr_count));

      // call takes the PC from valC and writes memory
      clr_strobes();
      icode = 4'h8;
      valC = 64'd400;
      valP = 64'd309;
      push("call_pc", 400);
      push("call_wr_cnt", 1);
      push("call_we_cnt", 1);
      step(6);
      cmp(PC);
      cmp(64'(cnt_wr));
      cmp(64'(cnt_we));
      mem_ready = 1'b0;

      if (sb.size() != 0) begin
         n_cmp++;
         n_fail++;
         $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/y86_seq_controller.md
Name: y86_seq_controller

Overview:
- Multi-cycle stage sequencer for the sequential Y86-64 datapath (fetch/decode/execute/memory/writeback).
- Owns the PC register, condition-code register and processor status. Issues one-cycle stage enables and handshakes with data memory.
- Retires exactly one instruction per pass through the stage FSM, replacing the free-running "PC<=valP every clock" style of sequencing.

Parameters:
- RESET_PC, 64'd64, PC value loaded on reset.
- MEM_TIMEOUT, 16, max cycles in MEMORY waiting for mem_ready before an ADR fault.
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- icode  input  4  from fetch.
- ifun  input  4  from fetch (informational; not used for sequencing).
- valid_instruction  input  1  fetch: opcode legal.
- valid_memory  input  1  fetch: PC address in range.
- valP  input  64  fall-through PC.
- valC  input  64  constant/destination.
- valM  input  64  memory read data (return address for ret).
- cnd  input  1  branch/cmov condition from execute.
- out_CC  input  3  new flags from execute {ZF,SF,OF}.
- mem_ready  input  1  memory access complete.
- mem_error  input  1  memory access faulted; sampled with mem_ready.
- PC  output  64  current PC.
- in_CC  output  3  architectural CC register to execute.
- stage  output  3  FSM state encoding.
- mem_rd  output  1  read request, held in MEMORY.
- mem_wr  output  1  write request, held in MEMORY.
- reg_we  output  1  register-file write strobe, one cycle in WRITEBACK.
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  output  1  high in HALT state.
- instr_count  output  CNT_WIDTH  retired instructions.

Behaviour:
- States and encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, PCUPD=5, HALT=6.
- Reset values: state FETCH; PC=RESET_PC; in_CC=3'b100; stat=AOK; instr_count=0; all strobes 0; halted=0.
- Reset asserted in any state, including MEMORY mid-access, aborts immediately. mem_rd/mem_wr drop the next cycle.
- FETCH:
  - valid_memory=0 -> stat=ADR, go to HALT.
  - else valid_instruction=0 -> stat=INS, go to HALT.
  - else icode=0 -> stat=HLT, go to HALT.
  - else go to DECODE.
  - On any fault PC is not modified.
- DECODE -> EXECUTE, unconditional, 1 cycle.
- EXECUTE:
  - icode=6 (OPq): in_CC<=out_CC at exit. No other icode writes CC.
  - Next state is MEMORY for icode in {4,5,8,9,A,B}, else WRITEBACK.
- MEMORY:
  - mem_wr=1 for icode 4,8,A; mem_rd=1 for 5,9,B. Strobes are combinational on state and icode.
  - Stay until mem_ready=1.
  - mem_ready=1 with mem_error=0 -> WRITEBACK.
  - mem_ready=1 with mem_error=1 -> stat=ADR, go to HALT.
  - Timeout counter resets on entry. After MEM_TIMEOUT cycles without mem_ready -> stat=ADR, go to HALT. Timeout and a ready arriving on the same cycle: ready wins.
- WRITEBACK:
  - reg_we=1 for icode in {2,3,5,6,8,9,A,B}. For icode 2, reg_we=cnd.
  - Then go to PCUPD.
- PCUPD:
  - PC next value: icode=7 -> (cnd ? valC : valP); icode=8 -> valC; icode=9 -> valM; else valP.
  - instr_count increments, wraps at 2^CNT_WIDTH.
  - Then go to FETCH.
- Latency: non-memory instruction = 5 cycles. Memory instruction = 6 + (mem_ready wait) cycles.
- HALT:
  - Absorbing; only reset exits.
  - PC, in_CC, stat and instr_count frozen; all strobes 0; halted=1.
  - Halt/faulting instructions are not counted.
- Widths: all PC arithmetic is 64-bit, no overflow detection; PC may wrap.

Test Plan:
- Reset with RESET_PC=64 -> PC=64, in_CC=100, stat=1, stage=0. Assert reset while in MEMORY -> next cycle stage=0, mem_rd=0.
- Program: nop @64, halt @65 -> PC=65 after 5 cycles, instr_count=1, stat=2, halted=1, PC stays 65.
- irmovq (icode 3, valP=74) -> reg_we pulses once in WRITEBACK, MEMORY skipped, PC=74 five cycles after FETCH.
- OPq with out_CC=010 -> in_CC=010 after EXECUTE. Following jXX with cnd=1, valC=200 -> PC=200. Same jXX with cnd=0, valP=105 -> PC=105.
- mrmovq with mem_ready delayed 3 cycles -> mem_rd high for 4 cycles, then WRITEBACK. Variant with mem_error=1 -> stat=3, halted, PC unchanged, reg_we never asserted.
- Cases:
  - valid_instruction=0 -> stat=4.
  - valid_memory=0 -> stat=3.
  - rmmovq with mem_ready never asserted -> stat=3 after 16 MEMORY cycles.
  - ret with valM=300 -> PC=300.
